fft_stage_sequencer: RTL

FFT_STAGE_SEQUENCER -- requirements
Module: fft_stage_sequencer

---
 rtl/fft_stage_sequencer_if.sv | 38 +++
 rtl/fft_stage_sequencer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/fft_stage_sequencer_if.sv
// fft_stage_sequencer_if
//   Bundles the request inputs and the address/write-back outputs of the
//   FFT stage sequencer.
//   Request:   start, run_all, stage[3:0]
//   Read side: addr_a, addr_b [N_LOG2-1:0], tw_idx [N_LOG2-2:0], dv
//   Write:     wr_addr_a, wr_addr_b [N_LOG2-1:0], o_we
//   Status:    cur_stage[3:0], busy, done, err
//   master = requester/consumer, slave = the sequencer.
interface fft_stage_sequencer_if #(
  parameter int N_LOG2 = 5
);
  logic              start;
  logic              run_all;
  logic [3:0]        stage;
  logic [N_LOG2-1:0] addr_a;
  logic [N_LOG2-1:0] addr_b;
  logic [N_LOG2-2:0] tw_idx;
  logic              dv;
  logic [N_LOG2-1:0] wr_addr_a;
  logic [N_LOG2-1:0] wr_addr_b;
  logic              o_we;
  logic [3:0]        cur_stage;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output start, run_all, stage,
    input  addr_a, addr_b, tw_idx, dv, wr_addr_a, wr_addr_b, o_we,
           cur_stage, busy, done, err
  );

  modport slave (
    input  start, run_all, stage,
    output addr_a, addr_b, tw_idx, dv, wr_addr_a, wr_addr_b, o_we,
           cur_stage, busy, done, err
  );
endinterface

// File: rtl/fft_stage_sequencer.sv
// fft_stage_sequencer
//   Issues radix-2 butterfly read addresses and twiddle indices for an
//   in-place N = 2^N_LOG2 point FFT, one butterfly per cycle, either for a
//   single stage or for all stages back to back with GAP_CYC idle cycles
//   between stages.  The issued addresses are delayed WR_LAT cycles to form
//   the write-back addresses and write enable.
//   Ports:
//     CLK  - clock, rising edge
//     rst  - synchronous active-high reset
//     bus  - fft_stage_sequencer_if slave modport (request, read addresses,
//            write-back addresses, status)
module fft_stage_sequencer #(
  parameter int N_LOG2  = 5,
  parameter int WR_LAT  = 2,
  parameter int GAP_CYC = 2
) (
  input  logic CLK,
  input  logic rst,
  fft_stage_sequencer_if.slave bus
);

  localparam int KW = N_LOG2 - 1;                 // butterfly counter width
  localparam int BW = 3 * N_LOG2 - 1;             // packed {a, b, tw}
  localparam logic [KW-1:0]     K_LAST     = '1;  // N/2 - 1
  localparam logic [KW-1:0]     K_ONE      = KW'(1);
  localparam logic [N_LOG2-1:0] ONE_N      = N_LOG2'(1);
  localparam logic [3:0]        LAST_STAGE = 4'(N_LOG2 - 1);
  localparam logic [3:0]        GAP_INIT   = 4'(GAP_CYC - 1);

  typedef enum logic [1:0] {IDLE, RUN, GAP, DRAIN} state_t;

  state_t            state_reg;
  logic [KW-1:0]     k_reg;
  logic [3:0]        stage_reg;
  logic              run_all_reg;
  logic [3:0]        gap_reg;
  logic [N_LOG2-1:0] addr_a_reg;
  logic [N_LOG2-1:0] addr_b_reg;
  logic [KW-1:0]     tw_reg;
  logic              dv_reg;
  logic              busy_reg;
  logic              done_reg;
  logic              err_reg;

  logic              we_pipe [WR_LAT];
  logic [N_LOG2-1:0] wa_pipe [WR_LAT];
  logic [N_LOG2-1:0] wb_pipe [WR_LAT];

  logic [3:0] start_stage;
  logic       start_bad;
  logic       pend_early;
  logic       drain_ok;

  // Butterfly k of stage s: the pair (a, a + 2^s) inside group k >> s,
  // twiddle exponent scaled so that stage N_LOG2-1 uses every ROM entry.
  function automatic logic [BW-1:0] bfly(input logic [KW-1:0] k,
                                         input logic [3:0]    s);
    logic [N_LOG2-1:0] half;
    logic [N_LOG2-1:0] pos;
    logic [N_LOG2-1:0] grp;
    logic [N_LOG2-1:0] a;
    logic [N_LOG2-1:0] b;
    logic [N_LOG2-1:0] tw_full;
    logic [3:0]        sh;
    half    = ONE_N << s;
    pos     = N_LOG2'(k) & (half - ONE_N);
    grp     = N_LOG2'(k) >> s;
    a       = (grp << (s + 4'd1)) | pos;
    b       = a + half;
    sh      = 4'(KW) - s;
    tw_full = pos << sh;
    return {a, b, tw_full[KW-1:0]};
  endfunction

  always_comb begin
    start_stage = bus.run_all ? 4'd0 : bus.stage;
    start_bad   = !bus.run_all && (bus.stage > LAST_STAGE);
  end

  // The run may finish once the only write still in flight is the one
  // presented on o_we this cycle.
  always_comb begin
    pend_early = 1'b0;
    for (int i = 0; i < WR_LAT - 1; i++) begin
      pend_early = pend_early | we_pipe[i];
    end
    drain_ok = we_pipe[WR_LAT-1] && !pend_early;
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_reg   <= IDLE;
      k_reg       <= '0;
      stage_reg   <= '0;
      run_all_reg <= 1'b0;
      gap_reg     <= '0;
      addr_a_reg  <= '0;
      addr_b_reg  <= '0;
      tw_reg      <= '0;
      dv_reg      <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      err_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            if (start_bad) begin
              err_reg <= 1'b1;
            end else begin
              state_reg   <= RUN;
              busy_reg    <= 1'b1;
              dv_reg      <= 1'b1;
              k_reg       <= '0;
              run_all_reg <= bus.run_all;
              stage_reg   <= start_stage;
              {addr_a_reg, addr_b_reg, tw_reg} <= bfly('0, start_stage);
            end
          end
        end
        RUN: begin
          if (k_reg == K_LAST) begin
            if (!run_all_reg || stage_reg == LAST_STAGE) begin
              state_reg <= DRAIN;
              dv_reg    <= 1'b0;
            end else if (GAP_CYC == 0) begin
              // No bubble: first butterfly of the next stage follows directly.
              stage_reg <= stage_reg + 4'd1;
              k_reg     <= '0;
              {addr_a_reg, addr_b_reg, tw_reg} <= bfly('0, stage_reg + 4'd1);
            end else begin
              state_reg <= GAP;
              dv_reg    <= 1'b0;
              stage_reg <= stage_reg + 4'd1;
              k_reg     <= '0;
              gap_reg   <= GAP_INIT;
            end
          end else begin
            k_reg <= k_reg + K_ONE;
            {addr_a_reg, addr_b_reg, tw_reg} <= bfly(k_reg + K_ONE, stage_reg);
          end
        end
        GAP: begin
          if (gap_reg == 4'd0) begin
            state_reg <= RUN;
            dv_reg    <= 1'b1;
            {addr_a_reg, addr_b_reg, tw_reg} <= bfly('0, stage_reg);
          end else begin
            gap_reg <= gap_reg - 4'd1;
          end
        end
        DRAIN: begin
          if (drain_ok) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Write-back pipeline: a plain delay line of the issued read side.
  always_ff @(posedge CLK) begin
    if (rst) begin
      for (int i = 0; i < WR_LAT; i++) begin
        we_pipe[i] <= 1'b0;
        wa_pipe[i] <= '0;
        wb_pipe[i] <= '0;
      end
    end else begin
      we_pipe[0] <= dv_reg;
      wa_pipe[0] <= addr_a_reg;
      wb_pipe[0] <= addr_b_reg;
      for (int i = 1; i < WR_LAT; i++) begin
        we_pipe[i] <= we_pipe[i-1];
        wa_pipe[i] <= wa_pipe[i-1];
        wb_pipe[i] <= wb_pipe[i-1];
      end
    end
  end

  assign bus.addr_a    = addr_a_reg;
  assign bus.addr_b    = addr_b_reg;
  assign bus.tw_idx    = tw_reg;
  assign bus.dv        = dv_reg;
  assign bus.wr_addr_a = wa_pipe[WR_LAT-1];
  assign bus.wr_addr_b = wb_pipe[WR_LAT-1];
  assign bus.o_we      = we_pipe[WR_LAT-1];
  assign bus.cur_stage = stage_reg;
  assign bus.busy      = busy_reg;
  assign bus.done      = done_reg;
  assign bus.err       = err_reg;

endmodule
